// File: rtl/bg_pkg.sv
// ============================================================================
//  Module      : bg_pkg
//  Description : Shared constants and types for the background-RAM loader:
//                frame geometry, stream opcodes, loader FSM states and the
//                pixel type.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bg_pkg;

  localparam int BG_W      = 160;
  localparam int BG_H      = 120;
  localparam int BG_PIXELS = BG_W * BG_H;
  localparam int PIX_W     = 6;
  localparam int ADDR_W    = 15;

  // Stream byte opcode, taken from in_data[7:6] while idle.
  typedef enum logic [1:0] {
    OP_LIT  = 2'd0,
    OP_RUN  = 2'd1,
    OP_SOF  = 2'd2,
    OP_RSVD = 2'd3
  } bg_op_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN_COUNT = 2'd1,
    S_RUN_FILL  = 2'd2
  } bg_ld_state_t;

  typedef logic [PIX_W-1:0] bg_pix_t;

endpackage

`default_nettype wire

// File: rtl/bg_addr_ctr.sv
// ============================================================================
//  Module      : bg_addr_ctr
//  Description : Wrapping raster address counter for the background RAM.
//                Holds the address of the next pixel write.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in   1       system clock
//    reset  in   1       synchronous active-high reset, address -> 0
//    inc    in   1       a write is issued at this address this cycle
//    clr    in   1       restart the frame at address 0
//    addr   out  ADDR_W  current (next-write) address
//    wrap   out  1       inc while addr is the last pixel of the frame
// ============================================================================
`default_nettype none

module bg_addr_ctr #(
  parameter int ADDR_W = 15,
  parameter int PIXELS = 19200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  // Last address computed at full address width so the compare never sees a
  // truncated row*width product.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  logic [ADDR_W-1:0] addr_q;

  assign wrap = inc && (addr_q == LAST_ADDR);
  assign addr = addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else if (clr) begin
      addr_q <= '0;
    end else if (inc) begin
      addr_q <= wrap ? '0 : addr_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bg_loader.sv
// ============================================================================
//  Module      : bg_loader
//  Description : Writer side of the 160x120 background pixel memory. Decodes
//                a run-length-encoded byte stream (valid/ready) into one RAM
//                write per cycle in raster order, wrapping at frame end.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk         in   1       system clock
//    reset       in   1       synchronous active-high reset
//    in_data     in   8       stream byte: [7:6] opcode, [5:0] colour
//    in_valid    in   1       in_data valid
//    in_ready    out  1       byte can be accepted this cycle
//    wr_en       out  1       RAM write strobe
//    wr_addr     out  ADDR_W  RAM write address (row*BG_W+col)
//    wr_data     out  PIX_W   RAM write data
//    frame_done  out  1       pulse with the write to the last pixel
//    busy        out  1       run fill in progress
//    err         out  1       sticky reserved-opcode flag, cleared by SOF
// ============================================================================
`default_nettype none

module bg_loader
  import bg_pkg::*;
#(
  parameter int BG_W   = 160,
  parameter int BG_H   = 120,
  parameter int PIX_W  = 6,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              err
);

  localparam int PIXELS = BG_W * BG_H;

  bg_ld_state_t      state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;      // writes still to issue after the first
  logic [PIX_W-1:0]  col_q, col_d;      // latched run colour
  logic              err_q, err_d;
  logic              rdy_q;
  logic              wr_en_q, fd_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;

  logic              accept;
  logic              do_wr;
  logic [PIX_W-1:0]  wcol;
  logic              a_clr;
  logic              a_wrap;
  logic [ADDR_W-1:0] a_addr;
  bg_op_t            op;

  assign accept = in_valid & rdy_q;
  assign op     = bg_op_t'(in_data[7:6]);

  bg_addr_ctr #(
    .ADDR_W (ADDR_W),
    .PIXELS (PIXELS)
  ) u_addr_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (do_wr),
    .clr   (a_clr),
    .addr  (a_addr),
    .wrap  (a_wrap)
  );

  // The first pixel of a run is issued on the same edge the count byte is
  // accepted, so the fill state lasts exactly n+1 cycles of visible writes;
  // cnt_q then counts the remaining n writes down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    err_d   = err_q;
    do_wr   = 1'b0;
    wcol    = col_q;
    a_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_LIT: begin
              do_wr = 1'b1;
              wcol  = in_data[PIX_W-1:0];
            end
            OP_RUN: begin
              col_d   = in_data[PIX_W-1:0];
              state_d = S_RUN_COUNT;
            end
            OP_SOF: begin
              a_clr = 1'b1;
              err_d = 1'b0;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end
      S_RUN_COUNT: begin
        // Every byte here is a count, whatever its top bits.
        if (accept) begin
          do_wr   = 1'b1;
          cnt_d   = {1'b0, in_data};
          state_d = S_RUN_FILL;
        end
      end
      S_RUN_FILL: begin
        if (cnt_q != 9'd0) begin
          do_wr = 1'b1;
          cnt_d = cnt_q - 9'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      col_q     <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      fd_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      err_q   <= err_d;
      // Registered copy of (state != RUN_FILL); also holds ready low for the
      // cycle following reset.
      rdy_q   <= (state_d != S_RUN_FILL);
      wr_en_q <= do_wr;
      fd_q    <= a_wrap;
      if (do_wr) begin
        wr_addr_q <= a_addr;
        wr_data_q <= wcol;
      end
    end
  end

  assign in_ready   = rdy_q;
  assign busy       = (state_q == S_RUN_FILL);
  assign err        = err_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_bg_loader.sv
// ============================================================================
//  Module      : tb_bg_loader
//  Description : Self-checking bench for bg_loader. A stream-level reference
//                model turns every accepted byte into a queue of expected
//                RAM writes; a negedge monitor compares the DUT writes with
//                that queue. Directed sequences cover latency, ready timing,
//                SOF/err, frame wrap and reset mid-run.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bg_loader;

  localparam int NPIX = 160 * 120;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [5:0]  wr_data;
  logic        frame_done;
  logic        busy;
  logic        err;

  bg_loader #(
    .BG_W   (160),
    .BG_H   (120),
    .PIX_W  (6),
    .ADDR_W (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int addr;
    int data;
    bit fd;
  } wr_t;

  typedef struct {
    logic [7:0] b;
    int         addr;
    logic [5:0] data;
  } lit_vec_t;

  wr_t expq[$];
  int  m_addr = 0;
  bit  m_pend = 1'b0;
  int  m_col  = 0;
  bit  m_err  = 1'b0;
  bit  mon_on = 1'b0;
  int  fd_count = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (stream level) ----------------
  function automatic void push_wr(input int d);
    wr_t w;
    w.addr = m_addr;
    w.data = d;
    w.fd   = (m_addr == NPIX - 1);
    expq.push_back(w);
    m_addr = (m_addr + 1) % NPIX;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_pend) begin
      for (int i = 0; i <= int'(b); i++) push_wr(m_col);
      m_pend = 1'b0;
    end else begin
      case (b[7:6])
        2'b00: push_wr(int'(b[5:0]));
        2'b01: begin m_col = int'(b[5:0]); m_pend = 1'b1; end
        2'b10: begin m_addr = 0; m_err = 1'b0; end
        default: m_err = 1'b1;
      endcase
    end
  endfunction

  function automatic void model_reset();
    expq.delete();
    m_addr = 0;
    m_pend = 1'b0;
    m_col  = 0;
    m_err  = 1'b0;
  endfunction

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      if (wr_en) begin
        if (expq.size() == 0) begin
          chk(1'b0, "unexpected_write_addr", wr_addr, -1);
        end else begin
          wr_t w;
          w = expq.pop_front();
          chk(wr_addr == w.addr, "mon_wr_addr", wr_addr, w.addr);
          chk(wr_data == w.data, "mon_wr_data", wr_data, w.data);
          chk(frame_done == w.fd, "mon_frame_done", frame_done, w.fd);
        end
      end else begin
        chk(frame_done == 1'b0, "frame_done_without_write", frame_done, 0);
      end
      if (frame_done) fd_count++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      chk(1'b0, "send_ready_timeout", t, 1000);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_byte(b);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk(expq.size() == 0, "drain_pending_writes", expq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(in_ready == 1'b0, {tag, "_in_ready"}, in_ready, 0);
    chk(wr_en == 1'b0, {tag, "_wr_en"}, wr_en, 0);
    chk(wr_addr == 15'd0, {tag, "_wr_addr"}, wr_addr, 0);
    chk(wr_data == 6'd0, {tag, "_wr_data"}, wr_data, 0);
    chk(frame_done == 1'b0, {tag, "_frame_done"}, frame_done, 0);
    chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
    chk(err == 1'b0, {tag, "_err"}, err, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lit_vec_t tbl[3];
    int low;
    int fd_base;
    int r;

    tbl[0] = '{8'h05, 0, 6'h05};
    tbl[1] = '{8'h2A, 1, 6'h2A};
    tbl[2] = '{8'h3F, 2, 6'h3F};

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "post_reset_in_ready", in_ready, 1);
    mon_on = 1'b1;

    // 1. LIT stream, in_valid held high, write one cycle after accept
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].b);
      chk(wr_en == 1'b1, "t1_wr_en", wr_en, 1);
      chk(wr_addr == tbl[i].addr, "t1_wr_addr", wr_addr, tbl[i].addr);
      chk(wr_data == tbl[i].data, "t1_wr_data", wr_data, tbl[i].data);
    end

    // 2. RUN 0x4C count 3: four writes, ready low exactly four cycles
    send(8'h4C);
    chk(in_ready == 1'b1, "t2_ready_in_count", in_ready, 1);
    send(8'h03);
    low = 0;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) break;
      chk(busy == 1'b1, "t2_busy", busy, 1);
      chk(wr_en == 1'b1, "t2_wr_en", wr_en, 1);
      chk(wr_addr == 3 + low, "t2_wr_addr", wr_addr, 3 + low);
      chk(wr_data == 6'h0C, "t2_wr_data", wr_data, 12);
      low++;
      @(posedge clk); #1;
    end
    chk(low == 4, "t2_ready_low_cycles", low, 4);
    chk(busy == 1'b0, "t2_busy_after", busy, 0);
    chk(wr_en == 1'b0, "t2_wr_en_after", wr_en, 0);

    // 3. LITs, SOF while the last LIT write is presented, LIT to addr 0, err
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk(wr_addr == 15'd9, "t3_last_lit_addr", wr_addr, 9);
    send(8'h80);
    chk(wr_en == 1'b0, "t3_sof_no_write", wr_en, 0);
    send(8'h11);
    chk(wr_addr == 15'd0, "t3_after_sof_addr", wr_addr, 0);
    chk(wr_data == 6'h11, "t3_after_sof_data", wr_data, 17);
    send(8'hC0);
    chk(err == 1'b1, "t3_err_set", err, 1);
    chk(wr_en == 1'b0, "t3_rsvd_no_write", wr_en, 0);
    send(8'h80);
    chk(err == 1'b0, "t3_err_cleared", err, 0);

    // 4. Whole frame by runs: one frame_done, then wrap to 0
    send(8'h80);
    fd_base = fd_count;
    for (int i = 0; i < 75; i++) begin
      send(8'h41);
      send(8'hFF);
    end
    drain();
    chk(fd_count - fd_base == 1, "t4_frame_done_pulses", fd_count - fd_base, 1);
    send(8'h22);
    chk(wr_addr == 15'd0, "t4_next_lit_addr", wr_addr, 0);

    // 5. Run straddling the frame end
    send(8'h80);
    for (int i = 0; i < 74; i++) begin
      send(8'h41);
      send(8'hFF);
    end
    send(8'h41);
    send(8'hFD);
    drain();
    fd_base = fd_count;
    send(8'h47);
    send(8'h03);
    chk(wr_addr == 15'd19198, "t5_first_run_addr", wr_addr, 19198);
    drain();
    chk(fd_count - fd_base == 1, "t5_frame_done_pulses", fd_count - fd_base, 1);
    send(8'h01);
    chk(wr_addr == 15'd2, "t5_after_wrap_addr", wr_addr, 2);

    // 6. Reset asserted in the middle of a long run
    send(8'h4A);
    send(8'hFF);
    idle(5);
    chk(busy == 1'b1, "t6_busy_before_reset", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_reset_outputs("t6_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "t6_ready_after_reset", in_ready, 1);
    chk(wr_en == 1'b0, "t6_no_write_after_reset", wr_en, 0);
    idle(3);
    send(8'h15);
    chk(wr_addr == 15'd0, "t6_post_reset_lit_addr", wr_addr, 0);
    chk(wr_data == 6'h15, "t6_post_reset_lit_data", wr_data, 21);

    // 7. Random stream with random in_valid gaps against the model
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 45) begin
        send({2'b00, 6'($urandom)});
      end else if (r < 75) begin
        send({2'b01, 6'($urandom)});
        idle($urandom_range(0, 2));
        if ($urandom_range(0, 99) < 80) send(8'($urandom_range(0, 12)));
        else send(8'($urandom));
      end else if (r < 88) begin
        send({2'b10, 6'($urandom)});
      end else begin
        send({2'b11, 6'($urandom)});
      end
    end
    drain();
    chk(err == m_err, "t7_err_vs_model", err, m_err);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
